burst_capture_ctrl: RTL and testbench
=====================================

Name: burst_capture_ctrl

Overview:
- Next-generation capture controller for memory speed testing.
- Takes NUM_CHANNELS digit-serial DUT output words every clk cycle and gearboxes BURST_INDEX consecutive samples into one wide RAM word, all in a single clock domain.
- Supports single-shot, circular (stop-triggered) and readback modes, with a valid/ready readback stream and status counters.
- Sits between the DUT/LFSR datapath and the host readout logic, replacing the separate address/control/RAM trio.

Parameters:
- DATA_WIDTH, 27, bits per channel sample, = (no_of_digits+1)*radix_bits
- NUM_CHANNELS, 2, independent sample lanes captured in lockstep
- BURST_INDEX, 8, samples per channel packed into one RAM word (>=2)
- ADDRESS_WIDTH, 10, RAM address bits
- MAX_RAM_ADDRESS, 1024, RAM depth in words (<= 2^ADDRESS_WIDTH)

Ports:
- clk  in  1  capture/readback clock
- reset  in  1  asynchronous, active-low
- start_signal  in  1  begin operation selected by mode; sampled only in IDLE or DONE
- mode  in  2  00 single capture, 01 circular capture, 10 readback, 11 reserved (treated as 00)
- trigger  in  1  in ARM, the first high cycle starts capture
- stop_signal  in  1  ends circular capture; aborts any mode
- din  in  NUM_CHANNELS*DATA_WIDTH  channel samples, channel 0 in LSBs
- rd_data  out  NUM_CHANNELS*DATA_WIDTH*BURST_INDEX  readback word; sample 0 in LSBs within each channel field, channel fields ordered channel 0 first
- rd_valid  out  1  rd_data valid
- rd_ready  in  1  consumer accepts rd_data
- ram_addr  out  ADDRESS_WIDTH  current write/read pointer
- words_written  out  ADDRESS_WIDTH+1  words stored, saturating at MAX_RAM_ADDRESS
- wrapped  out  1  circular capture overwrote word 0 at least once
- busy  out  1  state is not IDLE and not DONE
- transfer_done  out  1  high while in DONE

Behaviour:
- Reset values (async, reset=0):
  - state IDLE
  - all outputs 0
  - sample counter and packing register 0
  - RAM contents undefined and not cleared
- States:
  - IDLE
  - ARM
  - CAPTURE
  - READBACK
  - DONE
- IDLE/DONE + start_signal:
  - mode 00/01/11 -> ARM; clears words_written, wrapped, ram_addr, sample counter.
  - mode 10 -> READBACK; words_written and wrapped are kept.
- ARM:
  - The cycle trigger=1 is sample 0 and is packed that cycle; state -> CAPTURE.
  - stop_signal in ARM -> DONE, nothing written.
- CAPTURE:
  - Each cycle packs din into slot sample_cnt of every channel field.
  - When sample_cnt = BURST_INDEX-1, the completed word (including the current din) is written at ram_addr that same edge, ram_addr increments and words_written increments (saturating).
  - Write latency: the last sample of a burst is in RAM at the following edge.
- Single mode:
  - After writing address MAX_RAM_ADDRESS-1 -> DONE.
  - ram_addr holds MAX_RAM_ADDRESS-1.
- Circular mode:
  - ram_addr wraps MAX_RAM_ADDRESS-1 -> 0 and wrapped is set.
  - Capture continues until stop_signal.
- Stop mid-burst:
  - The partial word is discarded.
  - A stop coinciding with a burst-completing cycle still writes that word, then -> DONE.
- READBACK:
  - Start address is 0 if wrapped=0, else ram_addr (oldest word).
  - Word count is words_written.
  - Registered RAM read: rd_valid rises 2 cycles after entry.
  - rd_data is held stable while rd_valid & !rd_ready.
  - Each rd_valid&rd_ready handshake advances the address (modulo MAX_RAM_ADDRESS); the next word is valid no later than 2 cycles later.
  - After the last word is accepted -> DONE, rd_valid=0.
  - words_written=0 -> DONE after 1 cycle, no rd_valid.
  - stop_signal -> DONE immediately, rd_valid drops.
- start_signal in ARM/CAPTURE/READBACK is ignored.
- Asynchronous reset mid-operation returns to IDLE with no further RAM writes.
- DONE persists until start_signal or reset.

Test Plan:
- Bench configuration: NUM_CHANNELS=2, BURST_INDEX=4, MAX_RAM_ADDRESS=8, DATA_WIDTH=27.
- Single mode, trigger at cycle 5, din=counter -> 8 words written, word k ch0 = {4k+3,4k+2,4k+1,4k}; DONE after 32 capture cycles; words_written=8; readback returns words 0..7 in order.
- Circular mode, stop after 44 capture cycles -> wrapped=1, words_written=8, ram_addr=3; readback order starts at address 3, first word samples 12..15.
- Stop asserted on capture cycle 6 (mid second burst) -> words_written=1; readback yields exactly 1 word.
- Readback with rd_ready toggling 1-0-0-1 -> rd_data stable across stalls; no word dropped or duplicated; transfer_done only after the last handshake.
- reset=0 during CAPTURE at word 3 -> all outputs 0 immediately; state IDLE; start_signal during CAPTURE ignored (ram_addr continues unchanged).

Source files
------------

// File: rtl/burst_capture_ctrl.sv
// Burst capture controller: packs BURST_INDEX samples per channel into one RAM word,
// with single-shot, circular and valid/ready readback modes.
module burst_capture_ctrl #(
    parameter int DATA_WIDTH      = 27,
    parameter int NUM_CHANNELS    = 2,
    parameter int BURST_INDEX     = 8,
    parameter int ADDRESS_WIDTH   = 10,
    parameter int MAX_RAM_ADDRESS = 1024
) (
    input  logic                                        clk,
    input  logic                                        reset,
    input  logic                                        start_signal,
    input  logic [1:0]                                  mode,
    input  logic                                        trigger,
    input  logic                                        stop_signal,
    input  logic [NUM_CHANNELS*DATA_WIDTH-1:0]          din,
    output logic [NUM_CHANNELS*DATA_WIDTH*BURST_INDEX-1:0] rd_data,
    output logic                                        rd_valid,
    input  logic                                        rd_ready,
    output logic [ADDRESS_WIDTH-1:0]                    ram_addr,
    output logic [ADDRESS_WIDTH:0]                      words_written,
    output logic                                        wrapped,
    output logic                                        busy,
    output logic                                        transfer_done
);
    localparam int WORD_W = NUM_CHANNELS * DATA_WIDTH * BURST_INDEX;
    localparam int CNT_W  = $clog2(BURST_INDEX);
    localparam int WCNT_W = ADDRESS_WIDTH + 1;

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] ARM      = 3'd1;
    localparam logic [2:0] CAPTURE  = 3'd2;
    localparam logic [2:0] READBACK = 3'd3;
    localparam logic [2:0] DONE     = 3'd4;

    localparam logic [CNT_W-1:0]         CNT_LAST   = CNT_W'(BURST_INDEX - 1);
    localparam logic [ADDRESS_WIDTH-1:0] ADDR_LAST  = ADDRESS_WIDTH'(MAX_RAM_ADDRESS - 1);
    localparam logic [WCNT_W-1:0]        WORDS_FULL = WCNT_W'(MAX_RAM_ADDRESS);

    logic [2:0]        state;
    logic              circ;
    logic [CNT_W-1:0]  sample_cnt;
    logic [WORD_W-1:0] pack;
    logic [WORD_W-1:0] pack_next;
    logic [WCNT_W-1:0] rd_left;
    logic              rd_fetched;
    logic              burst_last;
    logic              mem_we;
    logic              rd_fetch;
    logic [WORD_W-1:0] mem [MAX_RAM_ADDRESS];

    assign burst_last    = (sample_cnt == CNT_LAST);
    assign mem_we        = (state == CAPTURE) && burst_last;
    assign rd_fetch      = (state == READBACK) && !stop_signal && !rd_valid && !rd_fetched
                           && (rd_left != '0);
    assign busy          = (state != IDLE) && (state != DONE);
    assign transfer_done = (state == DONE);

    // Current din dropped into slot sample_cnt of every channel field.
    always_comb begin
        // NOTE: default assignment first so no path leaves pack_next unassigned (no latch).
        pack_next = pack;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            for (int s = 0; s < BURST_INDEX; s++) begin
                if (sample_cnt == CNT_W'(s))
                    pack_next[(c*BURST_INDEX + s)*DATA_WIDTH +: DATA_WIDTH] =
                        din[c*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // NOTE: the RAM array has no reset so it maps onto block RAM; contents are undefined after reset.
    always_ff @(posedge clk) begin
        if (mem_we)
            mem[ram_addr] <= pack_next;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            rd_data <= '0;
        else if (rd_fetch)
            rd_data <= mem[ram_addr];
    end

    // NOTE: all state updates are non-blocking so every register sees pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            circ          <= 1'b0;
            sample_cnt    <= '0;
            pack          <= '0;
            ram_addr      <= '0;
            words_written <= '0;
            wrapped       <= 1'b0;
            rd_valid      <= 1'b0;
            rd_fetched    <= 1'b0;
            rd_left       <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start_signal) begin
                        if (mode == 2'b10) begin
                            state      <= READBACK;
                            ram_addr   <= wrapped ? ram_addr : '0;
                            rd_left    <= words_written;
                            rd_fetched <= 1'b0;
                            rd_valid   <= 1'b0;
                        end else begin
                            state         <= ARM;
                            circ          <= (mode == 2'b01);
                            words_written <= '0;
                            wrapped       <= 1'b0;
                            ram_addr      <= '0;
                            sample_cnt    <= '0;
                        end
                    end
                end
                ARM: begin
                    if (stop_signal) begin
                        state <= DONE;
                    end else if (trigger) begin
                        pack       <= pack_next;
                        sample_cnt <= sample_cnt + CNT_W'(1);
                        state      <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    pack <= pack_next;
                    if (burst_last) begin
                        sample_cnt <= '0;
                        if (words_written != WORDS_FULL)
                            words_written <= words_written + WCNT_W'(1);
                        // Single mode parks on the last address; circular wraps to the oldest word.
                        if (!circ && ram_addr == ADDR_LAST) begin
                            state <= DONE;
                        end else if (ram_addr == ADDR_LAST) begin
                            ram_addr <= '0;
                            wrapped  <= 1'b1;
                        end else begin
                            ram_addr <= ram_addr + ADDRESS_WIDTH'(1);
                        end
                    end else begin
                        sample_cnt <= sample_cnt + CNT_W'(1);
                    end
                    if (stop_signal)
                        state <= DONE;
                end
                READBACK: begin
                    if (stop_signal) begin
                        state      <= DONE;
                        rd_valid   <= 1'b0;
                        rd_fetched <= 1'b0;
                    end else if (rd_valid) begin
                        if (rd_ready) begin
                            rd_valid <= 1'b0;
                            ram_addr <= (ram_addr == ADDR_LAST) ? '0 : ram_addr + ADDRESS_WIDTH'(1);
                            rd_left  <= rd_left - WCNT_W'(1);
                            if (rd_left == WCNT_W'(1))
                                state <= DONE;
                        end
                    end else if (rd_left == '0) begin
                        state <= DONE;
                    end else if (rd_fetched) begin
                        rd_valid   <= 1'b1;
                        rd_fetched <= 1'b0;
                    end else begin
                        rd_fetched <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_burst_capture_ctrl.sv
// Self-checking bench for burst_capture_ctrl: directed capture/readback scenarios with
// a sample-queue reference model of which bursts land in RAM and in what order.
module tb_burst_capture_ctrl;
    localparam int DW     = 27;
    localparam int NC     = 2;
    localparam int BI     = 4;
    localparam int AW     = 3;
    localparam int MAX    = 8;
    localparam int WORD_W = NC * DW * BI;

    logic              clk = 1'b0;
    logic              reset;
    logic              start_signal;
    logic [1:0]        mode;
    logic              trigger;
    logic              stop_signal;
    logic [NC*DW-1:0]  din;
    logic [WORD_W-1:0] rd_data;
    logic              rd_valid;
    logic              rd_ready;
    logic [AW-1:0]     ram_addr;
    logic [AW:0]       words_written;
    logic              wrapped;
    logic              busy;
    logic              transfer_done;

    int checks = 0;
    int errors = 0;
    logic [WORD_W-1:0] exp_rb[$];
    logic [WORD_W-1:0] first_word;

    burst_capture_ctrl #(
        .DATA_WIDTH(DW), .NUM_CHANNELS(NC), .BURST_INDEX(BI),
        .ADDRESS_WIDTH(AW), .MAX_RAM_ADDRESS(MAX)
    ) dut (
        .clk(clk), .reset(reset), .start_signal(start_signal), .mode(mode),
        .trigger(trigger), .stop_signal(stop_signal), .din(din),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .ram_addr(ram_addr), .words_written(words_written), .wrapped(wrapped),
        .busy(busy), .transfer_done(transfer_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [NC*DW-1:0] rand_din();
        return (NC*DW)'({$urandom(), $urandom()});
    endfunction

    // Counter stimulus: channel c carries i + 1000*c.
    function automatic logic [NC*DW-1:0] cnt_word(input int i);
        logic [NC*DW-1:0] v;
        for (int c = 0; c < NC; c++) v[c*DW +: DW] = DW'(i + 1000*c);
        return v;
    endfunction

    // One channel field holding samples base..base+BI-1, sample 0 lowest.
    function automatic logic [BI*DW-1:0] ramp_field(input int base);
        logic [BI*DW-1:0] f = '0;
        for (int s = 0; s < BI; s++) f = f | ((BI*DW)'(base + s) << (s*DW));
        return f;
    endfunction

    function automatic int exp_addr(input int n, input bit single);
        if (single) return (n >= MAX) ? MAX - 1 : n;
        return n % MAX;
    endfunction

    task automatic run_capture(input logic [1:0] m, input int trig_delay, input int ncap,
                               input bit cnt_din, input bit stop_last, input int start_at);
        logic [NC*DW-1:0]  smp[$];
        logic [WORD_W-1:0] w;
        bit single;
        int n, base;
        single = (m != 2'b01);
        mode = m; start_signal = 1'b1; tick(); start_signal = 1'b0;
        check("arm_busy", busy, 1);
        check("arm_ww", words_written, 0);
        check("arm_addr", ram_addr, 0);
        repeat (trig_delay) begin din = rand_din(); tick(); end
        for (int i = 0; i < ncap; i++) begin
            trigger      = (i == 0);
            din          = cnt_din ? cnt_word(i) : rand_din();
            stop_signal  = stop_last && (i == ncap - 1);
            start_signal = (i == start_at);
            if (i == start_at) mode = 2'b10;
            smp.push_back(din);
            tick();
            trigger = 1'b0; stop_signal = 1'b0; start_signal = 1'b0;
            check("cap_done", transfer_done,
                  (stop_last && i == ncap - 1) || (single && i + 1 == MAX*BI));
            if (i == start_at) begin
                check("ign_start_busy", busy, 1);
                check("ign_start_addr", ram_addr, exp_addr((i + 1) / BI, single));
            end
        end
        if (!(stop_last || (single && ncap == MAX*BI))) begin
            stop_signal = 1'b1; din = rand_din(); tick(); stop_signal = 1'b0;
        end
        // Only whole bursts survive; readback yields the newest MAX of them, oldest first.
        n = ncap / BI;
        base = (n > MAX) ? n - MAX : 0;
        exp_rb.delete();
        for (int k = base; k < n; k++) begin
            w = '0;
            for (int c = 0; c < NC; c++)
                for (int s = 0; s < BI; s++)
                    w[(c*BI + s)*DW +: DW] = smp[k*BI + s][c*DW +: DW];
            exp_rb.push_back(w);
        end
        check("cap_ww", words_written, (n < MAX) ? n : MAX);
        check("cap_wrapped", wrapped, !single && n >= MAX);
        check("cap_addr", ram_addr, exp_addr(n, single));
        check("cap_end_done", transfer_done, 1);
        check("cap_end_busy", busy, 0);
        tick();
        check("done_hold", transfer_done, 1);
    endtask

    // pat: 0 always ready, 1 ready pattern 1-0-0-1, 2 random ready.
    task automatic run_readback(input int pat);
        int n, idx, since;
        bit hs, stall, was_valid, first, fin;
        logic [WORD_W-1:0] held;
        n = exp_rb.size(); idx = 0; since = 0; first = 1'b1; fin = 1'b0;
        mode = 2'b10; rd_ready = 1'b0; start_signal = 1'b1; tick(); start_signal = 1'b0;
        check("rb_entry_valid", rd_valid, 0);
        check("rb_ww", words_written, n);
        for (int cyc = 0; cyc < 200 && !fin; cyc++) begin
            case (pat)
                0:       rd_ready = 1'b1;
                1:       rd_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
                default: rd_ready = 1'($urandom_range(0, 1));
            endcase
            hs        = (rd_valid === 1'b1) && rd_ready;
            stall     = (rd_valid === 1'b1) && !rd_ready;
            was_valid = (rd_valid === 1'b1);
            held      = rd_data;
            if (hs) begin
                if (idx < n) check("rb_data", rd_data, exp_rb[idx]);
                if (idx == 0) first_word = rd_data;
                idx++;
            end
            tick();
            since = hs ? 0 : since + 1;
            if (stall) begin
                check("rb_stall_valid", rd_valid, 1);
                check("rb_stall_data", rd_data, held);
            end
            if (!was_valid && rd_valid === 1'b1) begin
                if (first) check("rb_first_latency", since, 2);
                else       check("rb_next_latency", since <= 2, 1);
                first = 1'b0;
            end
            if (idx >= n) begin
                check("rb_done", transfer_done, 1);
                check("rb_done_valid", rd_valid, 0);
                fin = 1'b1;
            end else begin
                check("rb_not_done", transfer_done, 0);
            end
        end
        check("rb_count", idx, n);
        check("rb_finished", fin, 1);
        rd_ready = 1'b0;
    endtask

    initial begin
        reset = 1'b0; start_signal = 1'b0; mode = 2'b00; trigger = 1'b0;
        stop_signal = 1'b0; din = '0; rd_ready = 1'b0; first_word = '0;
        #3;
        check("rst_rd_data", rd_data, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_addr", ram_addr, 0);
        check("rst_ww", words_written, 0);
        check("rst_wrapped", wrapped, 0);
        check("rst_busy", busy, 0);
        check("rst_done", transfer_done, 0);
        #10 reset = 1'b1;

        // Single capture, counter data, trigger after 5 idle ARM cycles.
        run_capture(2'b00, 5, 32, 1'b1, 1'b0, -1);
        run_readback(0);
        check("single_word0_ch0", first_word[BI*DW-1:0], ramp_field(0));

        // Circular capture, 44 samples then stop: oldest word is samples 12..15.
        run_capture(2'b01, 2, 44, 1'b1, 1'b0, -1);
        run_readback(1);
        check("circ_word0_ch0", first_word[BI*DW-1:0], ramp_field(12));

        // Stop on capture cycle 6, mid second burst.
        run_capture(2'b00, 1, 6, 1'b0, 1'b1, -1);
        run_readback(2);

        // Circular stop on a burst-completing cycle, with an ignored start mid-capture.
        run_capture(2'b01, 3, 20, 1'b0, 1'b1, 9);
        run_readback(2);

        // Reserved mode behaves as single.
        run_capture(2'b11, 0, 32, 1'b0, 1'b0, -1);
        run_readback(1);

        // Readback aborted by stop while a word is stalled.
        mode = 2'b10; rd_ready = 1'b0; start_signal = 1'b1; tick(); start_signal = 1'b0;
        tick(); tick();
        check("abort_valid", rd_valid, 1);
        check("abort_data", rd_data, exp_rb[0]);
        stop_signal = 1'b1; tick(); stop_signal = 1'b0;
        check("abort_done", transfer_done, 1);
        check("abort_valid_drop", rd_valid, 0);
        check("abort_busy", busy, 0);

        // Stop in ARM together with trigger: nothing written; empty readback.
        mode = 2'b00; start_signal = 1'b1; tick(); start_signal = 1'b0;
        trigger = 1'b1; stop_signal = 1'b1; tick(); trigger = 1'b0; stop_signal = 1'b0;
        check("armstop_done", transfer_done, 1);
        check("armstop_ww", words_written, 0);
        check("armstop_addr", ram_addr, 0);
        exp_rb.delete();
        run_readback(0);

        // Async reset during circular capture at word 3.
        mode = 2'b01; start_signal = 1'b1; tick(); start_signal = 1'b0;
        for (int i = 0; i < 14; i++) begin
            trigger = (i == 0); din = rand_din();
            start_signal = (i == 13);
            if (i == 13) mode = 2'b10;
            tick();
            trigger = 1'b0; start_signal = 1'b0;
        end
        check("rst_cap_addr", ram_addr, 3);
        check("rst_cap_busy", busy, 1);
        #2 reset = 1'b0;
        #1;
        check("midrst_rd_data", rd_data, 0);
        check("midrst_valid", rd_valid, 0);
        check("midrst_addr", ram_addr, 0);
        check("midrst_ww", words_written, 0);
        check("midrst_wrapped", wrapped, 0);
        check("midrst_busy", busy, 0);
        check("midrst_done", transfer_done, 0);
        #3 reset = 1'b1;
        tick();
        check("postrst_busy", busy, 0);
        check("postrst_done", transfer_done, 0);
        exp_rb.delete();
        run_readback(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
